// File: rtl/game_frame_tx_if.sv
// Byte stream handshake between the frame packer and the UART transmitter.
// The master holds byte_data stable while byte_valid waits for byte_ready.
interface game_frame_tx_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/game_frame_tx.sv
// game_frame_tx: captures N_FIELDS game-state fields and streams sync+payload bytes.
// Define FRAME_CHECKSUM_EN to append a mod-256 payload checksum byte.
module game_frame_tx #(
    parameter int unsigned N_FIELDS  = 4,
    parameter int unsigned FIELD_W   = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        snap_req,
    input  logic [N_FIELDS*FIELD_W-1:0] fields_in,
    game_frame_tx_if.master             tx,
    output logic                        busy,
    output logic                        frame_done,
    output logic [7:0]                  drop_cnt
);
    localparam int unsigned SW = N_FIELDS * FIELD_W;
    localparam int unsigned IW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;
`endif

    state_t        state_q, state_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          half_q, half_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    drop_q, drop_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    acc_q, acc_d;
`endif

    logic          xfer;
    logic [IW-1:0] idx_nxt;
    logic [15:0]   first_w, cur_w, nxt_w;

    // Fields are zero-extended to a 16-bit word before splitting into bytes.
    function automatic logic [15:0] field_word(
        input logic [SW-1:0] s,
        input logic [IW-1:0] k
    );
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (k == IW'(i)) w[FIELD_W-1:0] = s[i*FIELD_W +: FIELD_W];
        end
        return w;
    endfunction

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        half_d       = half_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        drop_d       = drop_q;
`ifdef FRAME_CHECKSUM_EN
        acc_d        = acc_q;
`endif
        xfer    = byte_valid_q && tx.byte_ready;
        idx_nxt = idx_q + 1'b1;
        first_w = field_word(shadow_q, '0);
        cur_w   = field_word(shadow_q, idx_q);
        nxt_w   = field_word(shadow_q, idx_nxt);

        if (snap_req && busy_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        unique case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    shadow_d     = fields_in;
`ifdef FRAME_CHECKSUM_EN
                    acc_d        = '0;
`endif
                    state_d      = S_SYNC;
                    byte_data_d  = SYNC_BYTE;
                    byte_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            S_SYNC: begin
                if (xfer) begin
                    state_d     = S_DATA;
                    idx_d       = '0;
                    half_d      = 1'b1;
                    byte_data_d = first_w[15:8];
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
                    acc_d = acc_q + byte_data_q;
`endif
                    if (half_q) begin
                        half_d      = 1'b0;
                        byte_data_d = cur_w[7:0];
                    end else if (idx_q == IW'(N_FIELDS - 1)) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d      = S_CSUM;
                        byte_data_d  = acc_q + byte_data_q;
`else
                        state_d      = S_IDLE;
                        byte_data_d  = '0;
                        byte_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
`endif
                    end else begin
                        idx_d       = idx_nxt;
                        half_d      = 1'b1;
                        byte_data_d = nxt_w[15:8];
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d      = S_IDLE;
                    byte_data_d  = '0;
                    byte_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            idx_q        <= '0;
            half_q       <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
`ifdef FRAME_CHECKSUM_EN
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            half_q       <= half_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
`ifdef FRAME_CHECKSUM_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign tx.byte_data  = byte_data_q;
    assign tx.byte_valid = byte_valid_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign drop_cnt      = drop_q;
endmodule

// File: doc/game_frame_tx.md
# game_frame_tx

Parametrised frame packer for the board-to-board game link. On a snapshot request it captures `N_FIELDS` game-state fields (positions, scores, flags) and emits them as a byte stream to the UART transmitter. The stream is a sync byte, then two bytes per field, then an optional checksum, using a valid/ready byte handshake. It replaces the fixed 16-bit word multiplexer that sits between game logic and `uart`, and it reports snapshots dropped while a frame is in flight.

## Interface
Parameters:
- `N_FIELDS`, 4: number of fields per frame; range 1–32.
- `FIELD_W`, 12: bits per field; range 1–16.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk` in 1: single clock (65 MHz pixel clock domain).
- `rst` in 1: asynchronous, active-low reset.
- `snap_req` in 1: single-cycle request to capture and send `fields_in`.
- `fields_in` in `N_FIELDS*FIELD_W`: field i is `fields_in[i*FIELD_W +: FIELD_W]`.
- `byte_data` out 8: current byte offered to the UART.
- `byte_valid` out 1: `byte_data` is valid.
- `byte_ready` in 1: the UART accepts the byte this cycle.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the final byte of a frame is accepted.
- `drop_cnt` out 8: saturating count of snapshots ignored because the block was busy.

## Operation
- States:
  - IDLE → SYNC → DATA → CSUM → IDLE.
  - CSUM exists only with `FRAME_CHECKSUM_EN`.
- IDLE:
  - `snap_req`=1 latches all of `fields_in` into a shadow register and clears the checksum accumulator.
  - The block then enters SYNC.
- A byte transfer occurs on a rising edge where `byte_valid`=1 and `byte_ready`=1.
- While `byte_valid`=1, `byte_data` stays constant until the transfer.
- `byte_valid` never drops without a transfer.
- SYNC:
  - `byte_data`=`SYNC_BYTE`.
  - After the transfer the block enters DATA with field index 0 and half=high.
- DATA:
  - Each field is zero-extended to 16 bits. The high byte is sent first, then the low byte.
  - Fields are sent in index order 0..N_FIELDS-1.
  - A field-index counter and a half bit advance on each transfer.
  - After the low byte of the last field transfers, the block goes to CSUM, or to IDLE if the checksum is compiled out.
- Checksum:
  - Mod-256 sum of all payload bytes. The sync byte is excluded.
  - Accumulated on each DATA transfer.
- CSUM: `byte_data`=accumulator. After the transfer the block goes to IDLE.
- Frame length is `1+2*N_FIELDS` bytes, plus 1 with the checksum.
- `snap_req` while `busy`=1:
  - The request is ignored and the frame in flight is unaffected.
  - `drop_cnt` increments and saturates at 255.
  - The shadow register does not change, even if `fields_in` changes during the frame.
- Reset:
  - Any frame in progress is aborted immediately.
  - State=IDLE, `byte_valid`=0, `byte_data`=0, `busy`=0, `frame_done`=0, `drop_cnt`=0, shadow and accumulator cleared.
  - No `frame_done` is generated for the aborted frame.

## Timing
- All outputs are registered.
- Capture latency:
  - `snap_req` is sampled high at edge N.
  - `busy`=1 and `byte_valid`=1 with the sync byte from after edge N.
- Back-to-back transfers:
  - With `byte_ready` held at 1, one byte transfers per clock.
  - No bubble between bytes.
- Final byte transfers at edge M:
  - After edge M: `busy`=0, `byte_valid`=0, `frame_done`=1 for one cycle.
- A `snap_req` in the cycle where `frame_done`=1 is accepted as a new frame, not dropped.
- `byte_ready` asserted while `byte_valid`=0 has no effect.

## Configuration
- `FRAME_CHECKSUM_EN` defined:
  - The CSUM state and checksum byte are present.
  - Frame is `2+2*N_FIELDS` bytes.
- `FRAME_CHECKSUM_EN` not defined:
  - No accumulator and no CSUM state.
  - The frame ends after the last data byte, giving `1+2*N_FIELDS` bytes.
  - `frame_done` follows that byte's transfer.

## Test plan
- Basic frame, checksum on:
  - Setup: `N_FIELDS`=2, field0=12'h123, field1=12'h4AB, `byte_ready`=1, one `snap_req` pulse.
  - Required: bytes A5,01,23,04,AB,D3 on six consecutive cycles, then a one-cycle `frame_done`.
- Basic frame, checksum off:
  - Setup: same stimulus built without `FRAME_CHECKSUM_EN`.
  - Required: A5,01,23,04,AB, then `frame_done`.
- Backpressure:
  - Setup: `byte_ready` toggled pseudo-randomly.
  - Required: each byte held stable while `byte_valid`=1 and `byte_ready`=0; same byte sequence; no byte lost or duplicated.
- Drops and shadow stability:
  - Setup: 3 `snap_req` pulses during a frame, and `fields_in` changed mid-frame.
  - Required: `drop_cnt`=3; the frame still carries the captured values.
  - Setup: 300 drops.
  - Required: `drop_cnt`=255.
- Back-to-back frames:
  - Setup: `snap_req` asserted in the `frame_done` cycle.
  - Required: the next sync byte is valid the following cycle; `drop_cnt` unchanged.
- Reset mid-frame:
  - Setup: `rst`=0 asynchronously after the 3rd byte.
  - Required: `byte_valid`, `busy`, `drop_cnt` go to 0 immediately; no `frame_done`.
  - Setup: next `snap_req` after reset release.
  - Required: a full frame starting with A5.
